// File: rtl/evo_pmux_csr_pkg.sv
// rtl/evo_pmux_csr_pkg.sv - bit indices, fill FSM states and pattern helper for the pmux CSR block
package evo_pmux_csr_pkg;

   // CTL register bit positions
   localparam int CTL_AUTO_INC = 0;
   localparam int CTL_PAT_CMD  = 1;
   localparam int CTL_PAT_SHFT = 2;
   localparam int CTL_SEL_DIR  = 4;
   localparam int CTL_SEL_OUT  = 5;
   localparam int CTL_SEL_EN   = 6;
   localparam int CTL_SEL_ALL  = 7;
   localparam int CTL_PAT_LSB  = 24;

   // Bits of CTL that are actually stored; everything else reads back 0
   localparam logic [31:0] CTL_RW_MASK = 32'hFF00_00F7;

   // STS register bit positions
   localparam int STS_BUSY   = 0;
   localparam int STS_DONE   = 1;
   localparam int STS_IN_CHG = 2;
   localparam int STS_ERR    = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_t;

   // Pattern byte for fill index idx: rotated left by idx mod 8 when shft is set
   function automatic logic [7:0] pat_value(input logic [7:0] pat, input logic [7:0] idx,
                                            input logic shft);
      logic [15:0] dbl;
      logic [2:0]  amt;
      amt = shft ? 3'(idx % 8'd8) : 3'd0;
      dbl = {pat, pat} << amt;
      return dbl[15:8];
   endfunction

endpackage

// File: rtl/evo_pmux_rf.sv
// rtl/evo_pmux_rf.sv - MUX_WIDTH x PORT_DWIDTH register file with CSR and fill write ports
module evo_pmux_rf #(
   parameter int PORT_DWIDTH = 32,
   parameter int MUX_WIDTH   = 16,
   parameter int PTR_WIDTH   = $clog2(MUX_WIDTH)
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             csr_we,
   input  logic [PTR_WIDTH-1:0]             csr_idx,
   input  logic [PORT_DWIDTH-1:0]           csr_data,
   input  logic                             fill_we,
   input  logic [PTR_WIDTH-1:0]             fill_idx,
   input  logic [PORT_DWIDTH-1:0]           fill_data,
   input  logic [PTR_WIDTH-1:0]             rd_idx,
   output logic [PORT_DWIDTH-1:0]           rd_data,
   output logic [PORT_DWIDTH*MUX_WIDTH-1:0] flat
);

   logic [PORT_DWIDTH-1:0] mem [MUX_WIDTH];

   // Storage update; the fill engine wins over a CSR write to the same file
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < MUX_WIDTH; i++) mem[i] <= '0;
      end else if (fill_we) begin
         mem[fill_idx] <= fill_data;
      end else if (csr_we) begin
         mem[csr_idx] <= csr_data;
      end
   end

   assign rd_data = mem[rd_idx];

   for (genvar g = 0; g < MUX_WIDTH; g++) begin : g_flat
      assign flat[g*PORT_DWIDTH +: PORT_DWIDTH] = mem[g];
   end

endmodule

// File: rtl/evo_pmux_csr_burst.sv
// rtl/evo_pmux_csr_burst.sv - pin-mux CSR slave with burst writes, pattern fill and input capture
module evo_pmux_csr_burst
   import evo_pmux_csr_pkg::*;
#(
   parameter int CSR_AWIDTH  = 4,
   parameter int CSR_DWIDTH  = 32,
   parameter int PORT_DWIDTH = 32,
   parameter int MUX_WIDTH   = 16,
   parameter int PTR_WIDTH   = $clog2(MUX_WIDTH),
   parameter logic [CSR_AWIDTH-1:0] PMUX_CSR_CTL_ADDR   = CSR_AWIDTH'(0),
   parameter logic [CSR_AWIDTH-1:0] PMUX_CSR_STS_ADDR   = CSR_AWIDTH'(1),
   parameter logic [CSR_AWIDTH-1:0] PMUX_CSR_WRADR_ADDR = CSR_AWIDTH'(2),
   parameter logic [CSR_AWIDTH-1:0] PMUX_CSR_DIR_ADDR   = CSR_AWIDTH'(3),
   parameter logic [CSR_AWIDTH-1:0] PMUX_CSR_OUT_ADDR   = CSR_AWIDTH'(4),
   parameter logic [CSR_AWIDTH-1:0] PMUX_CSR_EN_ADDR    = CSR_AWIDTH'(5),
   parameter logic [CSR_AWIDTH-1:0] PMUX_CSR_IN_ADDR    = CSR_AWIDTH'(6)
) (
   input  logic                             clk,
   input  logic                             rstn,
   output logic [PORT_DWIDTH*MUX_WIDTH-1:0] pmux_dir_o,
   output logic [PORT_DWIDTH*MUX_WIDTH-1:0] pmux_out_o,
   output logic [PORT_DWIDTH*MUX_WIDTH-1:0] pmux_en_o,
   input  logic [PORT_DWIDTH-1:0]           pmux_in_i,
   input  logic [CSR_AWIDTH-1:0]            avs_csr_address,
   input  logic                             avs_csr_read,
   input  logic                             avs_csr_write,
   input  logic [CSR_DWIDTH-1:0]            avs_csr_writedata,
   output logic [CSR_DWIDTH-1:0]            avs_csr_readdata,
   output logic                             avs_csr_readdatavalid,
   output logic                             avs_csr_waitrequest,
   output logic                             avs_csr_waitresponse
);

   localparam logic [PTR_WIDTH-1:0] IDX_LAST = PTR_WIDTH'(MUX_WIDTH - 1);

   fill_state_t            state_q, state_d;
   logic [PTR_WIDTH-1:0]   idx_q, idx_d, wr_ptr_q;
   logic [31:0]            ctl_q;
   logic                   sts_done_q, sts_in_chg_q, sts_err_q;
   logic [PORT_DWIDTH-1:0] sync1_q, sync2_q, in_prev_q;
   logic [PORT_DWIDTH-1:0] fill_data, dir_rd, out_rd, en_rd;
   logic [CSR_DWIDTH-1:0]  rd_mux;
   logic                   hit_ctl, hit_sts, hit_wradr, hit_dir, hit_out, hit_en, hit_in;
   logic                   busy, wr_acc, pat_cmd_wr, fill_start, fill_nosel, fill_we, done_set;
   logic                   wradr_bad;

   assign hit_ctl   = avs_csr_address == PMUX_CSR_CTL_ADDR;
   assign hit_sts   = avs_csr_address == PMUX_CSR_STS_ADDR;
   assign hit_wradr = avs_csr_address == PMUX_CSR_WRADR_ADDR;
   assign hit_dir   = avs_csr_address == PMUX_CSR_DIR_ADDR;
   assign hit_out   = avs_csr_address == PMUX_CSR_OUT_ADDR;
   assign hit_en    = avs_csr_address == PMUX_CSR_EN_ADDR;
   assign hit_in    = avs_csr_address == PMUX_CSR_IN_ADDR;

   // While filling, anything that could disturb the files, pointer or fill config is stalled
   assign busy                 = state_q == ST_FILL;
   assign avs_csr_waitrequest  = busy & avs_csr_write &
                                 (hit_wradr | hit_dir | hit_out | hit_en | hit_ctl);
   assign avs_csr_waitresponse = 1'b0;
   assign wr_acc               = avs_csr_write & ~avs_csr_waitrequest;

   assign pat_cmd_wr = wr_acc & hit_ctl & avs_csr_writedata[CTL_PAT_CMD];
   assign fill_start = pat_cmd_wr & (|avs_csr_writedata[CTL_SEL_ALL:CTL_SEL_DIR]);
   assign fill_nosel = pat_cmd_wr & ~(|avs_csr_writedata[CTL_SEL_ALL:CTL_SEL_DIR]);
   assign wradr_bad  = avs_csr_writedata >= CSR_DWIDTH'(MUX_WIDTH);

   assign fill_data = {(PORT_DWIDTH/8){pat_value(ctl_q[31:CTL_PAT_LSB], 8'(idx_q),
                                                 ctl_q[CTL_PAT_SHFT])}};

   // Fill FSM state and index register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Fill FSM next state; a command landing in DONE restarts rather than being dropped
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      fill_we  = 1'b0;
      done_set = fill_nosel;
      case (state_q)
         ST_IDLE: begin
            if (fill_start) begin
               state_d = ST_FILL;
               idx_d   = '0;
            end
         end
         ST_FILL: begin
            fill_we = 1'b1;
            if (idx_q == IDX_LAST) state_d = ST_DONE;
            else                   idx_d   = idx_q + 1'b1;
         end
         ST_DONE: begin
            done_set = 1'b1;
            state_d  = fill_start ? ST_FILL : ST_IDLE;
            idx_d    = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // CTL register; PAT_CMD is a one-cycle pulse
   always_ff @(posedge clk) begin
      if (!rstn)                 ctl_q <= '0;
      else if (wr_acc & hit_ctl) ctl_q <= avs_csr_writedata[31:0] & CTL_RW_MASK;
      else                       ctl_q[CTL_PAT_CMD] <= 1'b0;
   end

   // Write pointer: explicit load (range checked) or auto-increment with wrap
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
      end else if (wr_acc & hit_wradr) begin
         if (!wradr_bad) wr_ptr_q <= avs_csr_writedata[PTR_WIDTH-1:0];
      end else if (wr_acc & (hit_dir | hit_out | hit_en) & ctl_q[CTL_AUTO_INC]) begin
         wr_ptr_q <= (wr_ptr_q == IDX_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
   end

   // Sticky status bits: a set event beats a same-cycle write-1-to-clear
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sts_done_q   <= 1'b0;
         sts_in_chg_q <= 1'b0;
         sts_err_q    <= 1'b0;
      end else begin
         sts_done_q   <= done_set | (sts_done_q &
                         ~(wr_acc & hit_sts & avs_csr_writedata[STS_DONE]));
         sts_in_chg_q <= (sync2_q != in_prev_q) | (sts_in_chg_q &
                         ~(wr_acc & hit_sts & avs_csr_writedata[STS_IN_CHG]));
         sts_err_q    <= (wr_acc & hit_wradr & wradr_bad) | (sts_err_q &
                         ~(wr_acc & hit_sts & avs_csr_writedata[STS_ERR]));
      end
   end

   // Two-flop synchroniser for the pins plus the previous value for change detection
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         in_prev_q <= '0;
      end else begin
         sync1_q   <= pmux_in_i;
         sync2_q   <= sync1_q;
         in_prev_q <= sync2_q;
      end
   end

   evo_pmux_rf #(.PORT_DWIDTH(PORT_DWIDTH), .MUX_WIDTH(MUX_WIDTH), .PTR_WIDTH(PTR_WIDTH)) u_rf_dir (
      .clk(clk), .rstn(rstn),
      .csr_we(wr_acc & hit_dir), .csr_idx(wr_ptr_q), .csr_data(avs_csr_writedata[PORT_DWIDTH-1:0]),
      .fill_we(fill_we & (ctl_q[CTL_SEL_DIR] | ctl_q[CTL_SEL_ALL])), .fill_idx(idx_q),
      .fill_data(fill_data), .rd_idx(wr_ptr_q), .rd_data(dir_rd), .flat(pmux_dir_o)
   );

   evo_pmux_rf #(.PORT_DWIDTH(PORT_DWIDTH), .MUX_WIDTH(MUX_WIDTH), .PTR_WIDTH(PTR_WIDTH)) u_rf_out (
      .clk(clk), .rstn(rstn),
      .csr_we(wr_acc & hit_out), .csr_idx(wr_ptr_q), .csr_data(avs_csr_writedata[PORT_DWIDTH-1:0]),
      .fill_we(fill_we & (ctl_q[CTL_SEL_OUT] | ctl_q[CTL_SEL_ALL])), .fill_idx(idx_q),
      .fill_data(fill_data), .rd_idx(wr_ptr_q), .rd_data(out_rd), .flat(pmux_out_o)
   );

   evo_pmux_rf #(.PORT_DWIDTH(PORT_DWIDTH), .MUX_WIDTH(MUX_WIDTH), .PTR_WIDTH(PTR_WIDTH)) u_rf_en (
      .clk(clk), .rstn(rstn),
      .csr_we(wr_acc & hit_en), .csr_idx(wr_ptr_q), .csr_data(avs_csr_writedata[PORT_DWIDTH-1:0]),
      .fill_we(fill_we & (ctl_q[CTL_SEL_EN] | ctl_q[CTL_SEL_ALL])), .fill_idx(idx_q),
      .fill_data(fill_data), .rd_idx(wr_ptr_q), .rd_data(en_rd), .flat(pmux_en_o)
   );

   // Read data select; unmapped addresses return 0
   always_comb begin
      rd_mux = '0;
      if      (hit_ctl)   rd_mux = CSR_DWIDTH'(ctl_q);
      else if (hit_sts)   rd_mux = CSR_DWIDTH'({sts_err_q, sts_in_chg_q, sts_done_q, busy});
      else if (hit_wradr) rd_mux = CSR_DWIDTH'(wr_ptr_q);
      else if (hit_dir)   rd_mux = CSR_DWIDTH'(dir_rd);
      else if (hit_out)   rd_mux = CSR_DWIDTH'(out_rd);
      else if (hit_en)    rd_mux = CSR_DWIDTH'(en_rd);
      else if (hit_in)    rd_mux = CSR_DWIDTH'(sync2_q);
   end

   // Registered read response, latency 1
   always_ff @(posedge clk) begin
      if (!rstn) begin
         avs_csr_readdata      <= '0;
         avs_csr_readdatavalid <= 1'b0;
      end else begin
         avs_csr_readdatavalid <= avs_csr_read;
         if (avs_csr_read) avs_csr_readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_evo_pmux_csr_burst.sv
// tb/tb_evo_pmux_csr_burst.sv - self-checking bench for evo_pmux_csr_burst
module tb_evo_pmux_csr_burst;

   localparam int MW = 16;
   localparam int PW = 32;
   localparam logic [3:0] A_CTL = 4'd0, A_STS = 4'd1, A_WRADR = 4'd2, A_DIR = 4'd3,
                          A_OUT = 4'd4, A_EN = 4'd5, A_IN = 4'd6;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [PW*MW-1:0] pmux_dir_o, pmux_out_o, pmux_en_o;
   logic [PW-1:0]   pmux_in_i = '0;
   logic [3:0]      avs_csr_address = '0;
   logic            avs_csr_read = 1'b0, avs_csr_write = 1'b0;
   logic [31:0]     avs_csr_writedata = '0;
   logic [31:0]     avs_csr_readdata;
   logic            avs_csr_readdatavalid, avs_csr_waitrequest, avs_csr_waitresponse;

   always #5 clk = ~clk;

   evo_pmux_csr_burst #(
      .CSR_AWIDTH(4), .CSR_DWIDTH(32), .PORT_DWIDTH(PW), .MUX_WIDTH(MW)
   ) dut (
      .clk(clk), .rstn(rstn),
      .pmux_dir_o(pmux_dir_o), .pmux_out_o(pmux_out_o), .pmux_en_o(pmux_en_o),
      .pmux_in_i(pmux_in_i),
      .avs_csr_address(avs_csr_address), .avs_csr_read(avs_csr_read),
      .avs_csr_write(avs_csr_write), .avs_csr_writedata(avs_csr_writedata),
      .avs_csr_readdata(avs_csr_readdata), .avs_csr_readdatavalid(avs_csr_readdatavalid),
      .avs_csr_waitrequest(avs_csr_waitrequest), .avs_csr_waitresponse(avs_csr_waitresponse)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state
   logic [31:0] m_rf [3][MW];
   int          m_ptr;
   logic [31:0] m_ctl, m_in;
   bit          m_done, m_chg, m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] fill_word(input logic [7:0] p, input int i, input bit sh);
      int s, pi, r;
      s  = sh ? (i % 8) : 0;
      pi = int'(p);
      r  = ((pi << s) | (pi >> (8 - s))) & 255;
      return 32'(r) * 32'h0101_0101;
   endfunction

   function automatic void model_reset();
      for (int f = 0; f < 3; f++) for (int i = 0; i < MW; i++) m_rf[f][i] = '0;
      m_ptr = 0; m_ctl = '0; m_done = 0; m_chg = 0; m_err = 0;
   endfunction

   // Returns 1 when the CTL value launches a fill
   function automatic bit model_ctl(input logic [31:0] d);
      m_ctl = d & 32'hFF00_00F5;
      if (!d[1]) return 0;
      m_done = 1;
      if (d[7:4] == 4'd0) return 0;
      for (int i = 0; i < MW; i++)
         for (int f = 0; f < 3; f++)
            if (d[7] || d[4+f]) m_rf[f][i] = fill_word(d[31:24], i, d[2]);
      return 1;
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] a);
      case (a)
         A_CTL:               return m_ctl;
         A_STS:               return {28'd0, m_err, m_chg, m_done, 1'b0};
         A_WRADR:             return 32'(m_ptr);
         A_DIR, A_OUT, A_EN:  return m_rf[int'(a) - 3][m_ptr];
         A_IN:                return m_in;
         default:             return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] rf_slice(input int f, input int i);
      case (f)
         0:       return pmux_dir_o[i*PW +: PW];
         1:       return pmux_out_o[i*PW +: PW];
         default: return pmux_en_o[i*PW +: PW];
      endcase
   endfunction

   task automatic csr_write(input logic [3:0] a, input logic [31:0] d, output int stalls);
      @(negedge clk);
      avs_csr_address = a; avs_csr_writedata = d; avs_csr_write = 1'b1; stalls = 0;
      while (avs_csr_waitrequest && stalls < 100) begin
         @(negedge clk);
         stalls++;
      end
      if (stalls >= 100) check("write_stall_bound", 32'(avs_csr_waitrequest), 32'd0);
      @(posedge clk); #1;
      avs_csr_write = 1'b0;
   endtask

   task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_csr_address = a; avs_csr_read = 1'b1;
      @(posedge clk); #1;
      avs_csr_read = 1'b0;
      @(negedge clk);
      check("readdatavalid", 32'(avs_csr_readdatavalid), 32'd1);
      d = avs_csr_readdata;
   endtask

   task automatic do_wr(input logic [3:0] a, input logic [31:0] d);
      int st;
      csr_write(a, d, st);
      case (a)
         A_CTL: begin
            m_ctl = d;
            if (model_ctl(d)) repeat (MW + 2) @(negedge clk);
            else @(negedge clk);
         end
         A_STS: begin
            if (d[1]) m_done = 0;
            if (d[2]) m_chg = 0;
            if (d[3]) m_err = 0;
         end
         A_WRADR: begin
            if (d < 32'(MW)) m_ptr = int'(d);
            else m_err = 1;
         end
         A_DIR, A_OUT, A_EN: begin
            m_rf[int'(a) - 3][m_ptr] = d;
            if (m_ctl[0]) m_ptr = (m_ptr + 1) % MW;
         end
         default: ;
      endcase
   endtask

   task automatic do_rd(input logic [3:0] a);
      logic [31:0] v;
      csr_read(a, v);
      check($sformatf("read_addr%0d", a), v, model_read(a));
   endtask

   task automatic check_flat();
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < MW; i++)
            check($sformatf("file%0d_entry%0d", f, i), rf_slice(f, i), m_rf[f][i]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      logic [31:0] v, v2;
      int st, stalls, op;
      logic [31:0] d;

      model_reset();
      m_in = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_waitrequest", 32'(avs_csr_waitrequest), 32'd0);
      check("rst_readdatavalid", 32'(avs_csr_readdatavalid), 32'd0);
      check("rst_readdata", avs_csr_readdata, 32'd0);
      check("waitresponse", 32'(avs_csr_waitresponse), 32'd0);
      check_flat();
      for (int a = 0; a < 7; a++) do_rd(4'(a));

      // Auto-increment burst
      do_wr(A_WRADR, 32'd3);
      do_wr(A_CTL, 32'd1);
      do_wr(A_DIR, 32'hA);
      do_wr(A_DIR, 32'hB);
      do_wr(A_DIR, 32'hC);
      check("burst_dir3", rf_slice(0, 3), 32'hA);
      check("burst_dir4", rf_slice(0, 4), 32'hB);
      check("burst_dir5", rf_slice(0, 5), 32'hC);
      csr_read(A_WRADR, v);
      check("burst_wradr", v, 32'd6);
      do_wr(A_WRADR, 32'd15);
      do_wr(A_DIR, 32'hD);
      csr_read(A_WRADR, v);
      check("wrap_wradr", v, 32'd0);
      check("wrap_dir15", rf_slice(0, 15), 32'hD);

      // Pattern fill with rotation into all files
      csr_write(A_CTL, 32'hA500_0096, st);
      csr_read(A_STS, v);
      check("fill_busy", 32'(v[0]), 32'd1);
      repeat (MW) @(negedge clk);
      void'(model_ctl(32'hA500_0096));
      for (int f = 0; f < 3; f++) begin
         check($sformatf("fill_f%0d_e0", f), rf_slice(f, 0), 32'hA5A5_A5A5);
         check($sformatf("fill_f%0d_e1", f), rf_slice(f, 1), 32'h4B4B_4B4B);
         check($sformatf("fill_f%0d_e8", f), rf_slice(f, 8), 32'hA5A5_A5A5);
      end
      csr_read(A_STS, v);
      check("fill_sts_done", v, 32'h2);
      check_flat();
      do_wr(A_STS, 32'h2);

      // DIR write stalled by a fill, issued for sampling at edge T+3
      csr_write(A_CTL, 32'h3C00_0012, st);
      void'(model_ctl(32'h3C00_0012));
      @(posedge clk); @(posedge clk); #1;
      avs_csr_address = A_DIR; avs_csr_writedata = 32'h1234_5678; avs_csr_write = 1'b1;
      stalls = 0;
      @(negedge clk);
      while (avs_csr_waitrequest && stalls < 100) begin
         stalls++;
         @(negedge clk);
      end
      @(posedge clk); #1;
      avs_csr_write = 1'b0;
      check("stall_cycles", 32'(stalls), 32'(MW - 2));
      m_rf[0][m_ptr] = 32'h1234_5678;
      @(negedge clk);
      check("stalled_write_landed", rf_slice(0, m_ptr), 32'h1234_5678);
      check_flat();
      do_rd(A_STS);
      do_wr(A_STS, 32'hF);

      // Input synchroniser and change flag
      @(negedge clk);
      pmux_in_i = 32'h20;
      csr_read(A_IN, v);
      csr_read(A_IN, v2);
      check("in_early", v, 32'h0);
      check("in_late", v2, 32'h20);
      m_in = 32'h20; m_chg = 1;
      do_rd(A_STS);
      do_wr(A_STS, 32'h4);
      do_rd(A_STS);

      // Out-of-range WRADR
      do_wr(A_WRADR, 32'd5);
      do_wr(A_WRADR, 32'd20);
      csr_read(A_WRADR, v);
      check("wradr_bad_ignored", v, 32'd5);
      csr_read(A_STS, v);
      check("wradr_bad_err", 32'(v[3]), 32'd1);
      do_wr(A_STS, 32'h8);

      // Randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         op = $urandom_range(0, 9);
         case (op)
            0: do_wr(A_WRADR, 32'($urandom_range(0, 20)));
            1, 2, 3: do_wr(4'(op + 2), $urandom);
            4, 5: do_rd(4'($urandom_range(0, 15)));
            6: begin
               d = $urandom;
               d[1] = ($urandom_range(0, 3) == 0);
               do_wr(A_CTL, d);
            end
            7: do_wr(A_STS, 32'($urandom_range(0, 15)));
            8: do_wr(4'($urandom_range(6, 15)), $urandom);
            default: begin
               st = $urandom_range(0, MW - 1);
               for (int f = 0; f < 3; f++)
                  check($sformatf("rand_f%0d_e%0d", f, st), rf_slice(f, st), m_rf[f][st]);
            end
         endcase
      end
      check_flat();

      // Reset in the middle of a fill
      csr_write(A_CTL, 32'h5A00_00F7, st);
      repeat (5) @(negedge clk);
      rstn = 1'b0;
      pmux_in_i = '0;
      @(posedge clk); #1;
      rstn = 1'b1;
      model_reset();
      m_in = '0;
      @(negedge clk);
      check("midfill_rst_waitrequest", 32'(avs_csr_waitrequest), 32'd0);
      check_flat();
      for (int a = 0; a < 7; a++) do_rd(4'(a));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/evo_pmux_csr_burst.md
# evo_pmux_csr_burst

Parametrised successor CSR block for driving one port's pin-mux (pmux) bus from an Avalon-MM CSR slave. Holds per-mux-input DIR/OUT/EN register files and an input capture register. Adds auto-increment burst writes, a multi-cycle pattern-fill engine with Avalon back-pressure, a synchronised input with change detection, and sticky status. Sits between the CSR interconnect and the port logic, one instance per port.

## Interface
- CSR_AWIDTH, 4, CSR address width.
- CSR_DWIDTH, 32, CSR data width; must be ≥ PORT_DWIDTH.
- PORT_DWIDTH, 32, pins per port; must be a multiple of 8.
- MUX_WIDTH, 16, mux inputs per pin; range 2..64.
- PTR_WIDTH, $clog2(MUX_WIDTH), width of the write pointer.
- PMUX_CSR_{CTL,STS,WRADR,DIR,OUT,EN,IN}_ADDR, 0..6, register addresses; set at integration.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset. One clock; reset is synchronous and active-low.
- pmux_dir_o / pmux_out_o / pmux_en_o  out  PORT_DWIDTH*MUX_WIDTH  slice i = register-file entry i. Reset value is 0.
- pmux_in_i  in  PORT_DWIDTH  asynchronous pin values.
- avs_csr_address  in  CSR_AWIDTH.
- avs_csr_read / avs_csr_write  in  1.
- avs_csr_writedata  in  CSR_DWIDTH.
- avs_csr_readdata  out  CSR_DWIDTH  reset value 0.
- avs_csr_readdatavalid  out  1  reset value 0.
- avs_csr_waitrequest  out  1  reset value 0.
- avs_csr_waitresponse  out  1  tied to 0.

## Operation
- CTL register (RW) bits:
  - [0] AUTO_INC.
  - [1] PAT_CMD: one-shot; self-clears the cycle after it is written.
  - [2] PAT_SHFT.
  - [4] SEL_DIR, [5] SEL_OUT, [6] SEL_EN, [7] SEL_ALL.
  - [31:24] PAT byte.
- STS register bits:
  - [0] BUSY: read-only.
  - [1] DONE, [2] IN_CHG, [3] ERR: sticky; writing 1 clears the bit.
  - A set event and a clear in the same cycle leaves the bit set.
- WRADR register: holds wr_ptr.
  - A write value ≥ MUX_WIDTH is ignored and sets ERR.
- Writes to DIR/OUT/EN store into entry [wr_ptr].
  - If AUTO_INC=1, wr_ptr increments on each accepted write and wraps from MUX_WIDTH-1 to 0.
- Reads of DIR/OUT/EN return entry [wr_ptr]; reads do not increment wr_ptr.
- IN register: pmux_in_i passed through a 2-flop synchroniser.
  - Read-only; writes are ignored.
  - IN_CHG sets whenever the synchronised value differs from its previous value.
- Read of an unmapped address returns 0 with readdatavalid asserted.
- Pattern-fill FSM:
  - States IDLE → FILL → DONE → IDLE.
  - IDLE → FILL on a CTL write with PAT_CMD=1 and at least one SEL bit set. With no SEL bit set, the FSM stays in IDLE and DONE sets.
  - FILL writes index idx = 0..MUX_WIDTH-1, one per cycle, into every selected file (SEL_ALL selects all three).
  - Fill value: the PAT byte, rotated left by (idx mod 8) if PAT_SHFT=1, then replicated to PORT_DWIDTH.
  - FILL → DONE after idx = MUX_WIDTH-1. DONE sets the DONE status bit, then returns to IDLE.
- During FILL (BUSY=1):
  - waitrequest is held high for writes to WRADR/DIR/OUT/EN/CTL. The master stalls until FILL exits.
  - Reads and STS writes proceed normally.
- Reset mid-fill: all files, wr_ptr, CTL and STS return to 0; the FSM returns to IDLE.

## Timing
- Writes take effect on the clock edge where write=1 and waitrequest=0. New pmux output values are visible the next cycle.
- Reads: readdata and readdatavalid are registered, one cycle after read=1. Read latency is 1.
- Fill start: PAT_CMD written at edge T.
  - FILL occupies edges T+1..T+MUX_WIDTH; entry i is written at edge T+1+i.
  - BUSY reads 1 after T+1 until T+MUX_WIDTH.
  - DONE status bit is set after edge T+MUX_WIDTH+1.
- Input path: a pin change appears in IN 2 cycles later. IN_CHG sets one cycle after that.
- waitrequest is combinational from the FSM state and the address decode.

## Structure
- Package evo_pmux_csr_pkg contains:
  - CTL and STS bit-index localparams.
  - fill_state_t enum.
  - A function pat_value(byte, idx, shft).
- Sub-module evo_pmux_rf: MUX_WIDTH × PORT_DWIDTH register file with one CSR write port, one fill write port (the fill port takes priority), a read mux, and a flat output bus. Instantiated three times (DIR, OUT, EN).
- Top level contains the CSR decode, wr_ptr, CTL/STS, the FSM and the synchroniser.

## Test plan
- Reset, then read all registers → all read 0, pmux outputs 0, waitrequest 0.
- WRADR=3, AUTO_INC=1, write DIR 0xA, 0xB, 0xC → entries 3/4/5 hold these values; WRADR reads 6. Write at wr_ptr=15 → wr_ptr wraps to 0.
- CTL=0xA5000096 (PAT_CMD, PAT_SHFT, SEL_DIR, SEL_ALL) →
  - All three files hold: entry 0 = 0xA5A5A5A5, entry 1 = 0x4B4B4B4B, entry 8 = 0xA5A5A5A5.
  - BUSY lasts 16 cycles; DONE sets after.
- DIR write issued at cycle T+3 of a fill → waitrequest stays high until FILL exits; the write lands afterwards, at the correct wr_ptr.
- Toggle pmux_in_i[5] → IN bit 5 updates after 2 cycles; IN_CHG sets; write STS=0x4 clears it.
- WRADR=20 with MUX_WIDTH=16 → wr_ptr unchanged and ERR set. Assert rstn mid-fill → all state returns to 0.
